ws2812b_receiver: RTL and testbench

//  Decodes a WS2812B single-wire NRZ pulse stream back into 24-bit pixel words.
//  It is the receive end of the LED data link, used for transmitter loopback checking and for chain-tap monitoring.

---
 rtl/ws2812b_pkg.sv | 22 ++
 rtl/ws2812b_receiver_if.sv | 28 ++
 rtl/ws2812b_rx_sync.sv | 38 +++
 rtl/ws2812b_receiver.sv | 199 +++++++++++++++++++
 tb/tb_ws2812b_receiver.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: receiver FSM states, pixel width and default 50 MHz timing,
// also used by the transmitter side of the link.
package ws2812b_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } rx_state_e;

    localparam int PIXEL_W = 24;

    // Default timing in 50 MHz clock cycles
    localparam int T0H_DEF          = 20;
    localparam int T1H_DEF          = 40;
    localparam int T_BIT_THRESH_DEF = 30;
    localparam int T_MIN_HIGH_DEF   = 8;
    localparam int T_MAX_HIGH_DEF   = 60;
    localparam int T_RESET_DEF      = 2500;

endpackage

// File: rtl/ws2812b_receiver_if.sv
// Pixel output port of the WS2812B receiver.
// A word transfers on a clock edge where pixel_valid && pixel_ready; the source holds
// pixel_valid, pixel_data and pixel_index stable until that edge, and pixel_ready may toggle freely.
interface ws2812b_receiver_if #(
    parameter int IDX_W = 10
);
    import ws2812b_pkg::*;

    logic [PIXEL_W-1:0] pixel_data;
    logic               pixel_valid;
    logic               pixel_ready;
    logic [IDX_W-1:0]   pixel_index;

    modport master (
        output pixel_data,
        output pixel_valid,
        output pixel_index,
        input  pixel_ready
    );

    modport slave (
        input  pixel_data,
        input  pixel_valid,
        input  pixel_index,
        output pixel_ready
    );

endinterface

// File: rtl/ws2812b_rx_sync.sv
// Two-flop synchroniser for the asynchronous WS2812B line plus rise/fall detection
// on the synchronised level.
module ws2812b_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~prev_q;
    assign fall  = ~s2_q & prev_q;

endmodule

// File: rtl/ws2812b_receiver.sv
// WS2812B NRZ receiver: measures high pulses, assembles 24-bit words MSB-first and detects frame end.
// Optional saturating error counter (err_count/err_clr) is built when WS2812B_RX_ERRCNT_EN is defined.
module ws2812b_receiver
    import ws2812b_pkg::*;
#(
    parameter int T_BIT_THRESH = T_BIT_THRESH_DEF,
    parameter int T_MIN_HIGH   = T_MIN_HIGH_DEF,
    parameter int T_MAX_HIGH   = T_MAX_HIGH_DEF,
    parameter int T_RESET      = T_RESET_DEF,
    parameter int CNT_W        = 12,
    parameter int IDX_W        = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data_in,
    ws2812b_receiver_if.master pix,
    output logic               frame_end,
    output logic               pulse_err,
    output logic               overflow,
    input  logic               ovf_clr,
`ifdef WS2812B_RX_ERRCNT_EN
    output logic [15:0]        err_count,
    input  logic               err_clr,
`endif
    output rx_state_e          state_dbg
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(T_BIT_THRESH);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(T_MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(T_MAX_HIGH);
    localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(T_RESET);
    localparam logic [4:0]       LAST_BIT = 5'(PIXEL_W - 1);

    logic level, rise, fall;

    ws2812b_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (data_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [PIXEL_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]   idx_cnt_q, idx_cnt_d;
    logic [PIXEL_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               valid_q, valid_d;
    logic               frame_end_q, frame_end_d;
    logic               pulse_err_q, pulse_err_d;
    logic               overflow_q, overflow_d;
    logic               word_done, clear_index, slot_free;

    always_comb begin
        // Width of the current level; an edge starts the new level at 1
        if (rise || fall) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        idx_cnt_d   = idx_cnt_q;
        frame_end_d = 1'b0;
        pulse_err_d = 1'b0;
        word_done   = 1'b0;
        clear_index = 1'b0;

        case (state_q)
            SYNC: begin
                if (!level && cnt_d >= RESET_C) state_d = IDLE;
            end
            IDLE: begin
                if (rise) state_d = HIGH;
            end
            HIGH: begin
                // cnt_q holds the completed high width on the fall cycle
                if (fall && cnt_q >= MIN_C && cnt_q <= MAX_C) begin
                    shift_d = {shift_q[PIXEL_W-2:0], (cnt_q >= THRESH_C)};
                    if (bit_cnt_q == LAST_BIT) begin
                        word_done = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                    state_d = LOW;
                end else if (fall || cnt_d > MAX_C) begin
                    pulse_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                    clear_index = 1'b1;
                    state_d     = SYNC;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (cnt_d >= RESET_C) begin
                    frame_end_d = 1'b1;
                    pulse_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                    clear_index = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = SYNC;
        endcase

        // Output slot: a handshake this cycle frees it for a word completing in the same cycle
        slot_free  = !valid_q || pix.pixel_ready;
        valid_d    = valid_q && !pix.pixel_ready;
        data_d     = data_q;
        index_d    = index_q;
        overflow_d = ovf_clr ? 1'b0 : overflow_q;

        if (word_done) begin
            idx_cnt_d = idx_cnt_q + IDX_W'(1);
            if (slot_free) begin
                valid_d = 1'b1;
                data_d  = shift_d;
                index_d = idx_cnt_q;
            end else begin
                overflow_d = 1'b1;
            end
        end

        // A pending word keeps its index; only an empty slot shows the restart at 0
        if (clear_index) begin
            idx_cnt_d = '0;
            if (!valid_d) index_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SYNC;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            idx_cnt_q   <= '0;
            data_q      <= '0;
            index_q     <= '0;
            valid_q     <= 1'b0;
            frame_end_q <= 1'b0;
            pulse_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            idx_cnt_q   <= idx_cnt_d;
            data_q      <= data_d;
            index_q     <= index_d;
            valid_q     <= valid_d;
            frame_end_q <= frame_end_d;
            pulse_err_q <= pulse_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pix.pixel_data  = data_q;
    assign pix.pixel_valid = valid_q;
    assign pix.pixel_index = index_q;
    assign frame_end       = frame_end_q;
    assign pulse_err       = pulse_err_q;
    assign overflow        = overflow_q;
    assign state_dbg       = state_q;

`ifdef WS2812B_RX_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = pulse_err_d ? 16'd1 : 16'd0;
        end else if (pulse_err_d && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ws2812b_receiver.sv
// Self-checking bench for ws2812b_receiver: pulse-level line driver, word scoreboard and
// directed checks for backpressure, glitch, truncation, stuck-high and mid-frame reset.
`timescale 1ns/1ps
module tb_ws2812b_receiver;
    import ws2812b_pkg::*;

    localparam int T_LOW = 20;
    localparam int GAP   = 2550;

    logic      clk = 1'b0;
    logic      reset;
    logic      data_in;
    logic      frame_end, pulse_err, overflow, ovf_clr;
    rx_state_e state_dbg;
`ifdef WS2812B_RX_ERRCNT_EN
    logic [15:0] err_count;
    logic        err_clr;
`endif

    ws2812b_receiver_if #(.IDX_W(10)) pix ();

    ws2812b_receiver dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .pix       (pix),
        .frame_end (frame_end),
        .pulse_err (pulse_err),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
`ifdef WS2812B_RX_ERRCNT_EN
        .err_count (err_count),
        .err_clr   (err_clr),
`endif
        .state_dbg (state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard and counters
    logic [33:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int exp_idx  = 0;
    int fe_cnt   = 0;
    int pe_cnt   = 0;
    int both_cnt = 0;
    int hs_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (frame_end) fe_cnt++;
            if (pulse_err) pe_cnt++;
            if (frame_end && pulse_err) both_cnt++;
            if (pix.pixel_valid && pix.pixel_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", pix.pixel_data, 32'hFFFF_FFFF);
                end else begin
                    logic [33:0] item;
                    item = exp_q.pop_front();
                    check_eq("pix_data", pix.pixel_data, {8'h0, item[23:0]});
                    check_eq("pix_index", {22'h0, pix.pixel_index}, {22'h0, item[33:24]});
                end
            end
        end
    end

    // Driver tasks
    task automatic send_pulse(input int hi, input int lo);
        data_in = 1'b1;
        repeat (hi) @(negedge clk);
        data_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_gap(input int n);
        data_in = 1'b0;
        repeat (n) @(negedge clk);
        exp_idx = 0;
    endtask

    // mode 0: plain; 1: check valid latency after the last fall; 2: raise ready just before the load edge
    task automatic send_word(input logic [23:0] w, input int h0, input int h1, input bit push, input int mode);
        if (push) exp_q.push_back({exp_idx[9:0], w});
        exp_idx = (exp_idx + 1) % 1024;
        for (int i = 23; i >= 1; i--) send_pulse(w[i] ? h1 : h0, T_LOW);
        data_in = 1'b1;
        repeat (w[0] ? h1 : h0) @(negedge clk);
        data_in = 1'b0;
        if (mode == 1) begin
            @(negedge clk); #1 check_eq("latency_n1", pix.pixel_valid, 0);
            @(negedge clk); #1 check_eq("latency_n2", pix.pixel_valid, 0);
            @(negedge clk); #1 check_eq("latency_n3", pix.pixel_valid, 1);
            repeat (T_LOW - 3) @(negedge clk);
        end else if (mode == 2) begin
            repeat (2) @(negedge clk);
            pix.pixel_ready = 1'b1;
            repeat (T_LOW - 2) @(negedge clk);
        end else begin
            repeat (T_LOW) @(negedge clk);
        end
    endtask

    task automatic send_bits(input logic [23:0] w, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) send_pulse(w[i] ? T1H_DEF : T0H_DEF, T_LOW);
    endtask

    initial begin
        int fe0, pe0, both0, n;
        bit seen;

        reset = 1'b1;
        data_in = 1'b0;
        ovf_clr = 1'b0;
        pix.pixel_ready = 1'b1;
`ifdef WS2812B_RX_ERRCNT_EN
        err_clr = 1'b0;
`endif
        repeat (5) @(negedge clk);
        #1;
        check_eq("rst_valid", pix.pixel_valid, 0);
        check_eq("rst_data", pix.pixel_data, 0);
        check_eq("rst_index", {22'h0, pix.pixel_index}, 0);
        check_eq("rst_frame_end", frame_end, 0);
        check_eq("rst_pulse_err", pulse_err, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_state", {30'h0, state_dbg}, {30'h0, SYNC});
        @(negedge clk);
        reset = 1'b0;

        // Initial resync gap: reaches IDLE without frame_end
        send_gap(GAP);
        check_eq("sync_state", {30'h0, state_dbg}, {30'h0, IDLE});
        check_eq("sync_no_frame_end", fe_cnt, 0);

        // Test 1: loopback frame, plus pulse-width boundary words
        send_word(24'hFF0000, T0H_DEF, T1H_DEF, 1'b1, 1);
        send_word(24'h00FF00, T0H_DEF, T1H_DEF, 1'b1, 0);
        send_word(24'h0000AA, T0H_DEF, T1H_DEF, 1'b1, 0);
        send_word(24'hA5A5A5, 8, 60, 1'b1, 0);
        send_word(24'h3C3C3C, 29, 30, 1'b1, 0);
        send_gap(GAP);
        check_eq("t1_handshakes", hs_cnt, 5);
        check_eq("t1_frame_end", fe_cnt, 1);
        check_eq("t1_no_err", pe_cnt, 0);
        check_eq("t1_index_zero", {22'h0, pix.pixel_index}, 0);
        check_eq("t1_queue_empty", exp_q.size(), 0);

        // Test 2: backpressure, overflow, ovf_clr, same-cycle handshake and load
        pix.pixel_ready = 1'b0;
        send_word(24'h123456, T0H_DEF, T1H_DEF, 1'b1, 0);
        send_word(24'h654321, T0H_DEF, T1H_DEF, 1'b0, 0);
        #1;
        check_eq("t2_held_valid", pix.pixel_valid, 1);
        check_eq("t2_held_data", pix.pixel_data, 32'h123456);
        check_eq("t2_held_index", {22'h0, pix.pixel_index}, 0);
        check_eq("t2_overflow_set", overflow, 1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        #1 check_eq("t2_overflow_clr", overflow, 0);
        send_word(24'h0F0F0F, T0H_DEF, T1H_DEF, 1'b1, 2);
        #1 check_eq("t2_no_drop", overflow, 0);
        send_gap(GAP);
        check_eq("t2_frame_end", fe_cnt, 2);
        check_eq("t2_queue_empty", exp_q.size(), 0);

        // Test 3: glitch at bit 10, recovery through SYNC
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        send_bits(24'hFFFFFF, 10);
        send_pulse(4, T_LOW);
        exp_idx = 0;
        check_eq("t3_pulse_err", pe_cnt, pe0 + 1);
        check_eq("t3_state_sync", {30'h0, state_dbg}, {30'h0, SYNC});
        send_gap(GAP);
        check_eq("t3_state_idle", {30'h0, state_dbg}, {30'h0, IDLE});
        check_eq("t3_no_frame_end", fe_cnt, fe0);
        send_word(24'hC0FFEE, T0H_DEF, T1H_DEF, 1'b1, 0);
        send_gap(GAP);
        check_eq("t3_frame_end", fe_cnt, fe0 + 1);

        // Test 4: truncated word
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        both0 = both_cnt;
        send_bits(24'hABCDEF, 12);
        send_gap(GAP);
        check_eq("t4_pulse_err", pe_cnt, pe0 + 1);
        check_eq("t4_frame_end", fe_cnt, fe0 + 1);
        check_eq("t4_same_cycle", both_cnt, both0 + 1);
        check_eq("t4_no_valid", pix.pixel_valid, 0);

        // Test 5: stuck high; error in the 61st synchronised high cycle
        n = 0;
        seen = 1'b0;
        data_in = 1'b1;
        while (!seen && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            if (pulse_err) seen = 1'b1;
        end
        check_eq("t5_stuck_latency", n, 2 + 61);
        data_in = 1'b0;
        send_gap(GAP);
        check_eq("t5_state_idle", {30'h0, state_dbg}, {30'h0, IDLE});

`ifdef WS2812B_RX_ERRCNT_EN
        check_eq("errcnt_value", err_count, 3);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1 check_eq("errcnt_clr", err_count, 0);
`endif

        // Test 6: reset mid-word, then a full frame
        send_bits(24'h777777, 15);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("t6_rst_state", {30'h0, state_dbg}, {30'h0, SYNC});
        check_eq("t6_rst_valid", pix.pixel_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        send_gap(GAP);
        send_word(24'h5A5A5A, T0H_DEF, T1H_DEF, 1'b1, 0);
        send_word(24'h0000FF, T0H_DEF, T1H_DEF, 1'b1, 0);
        send_gap(GAP);
        check_eq("t6_queue_empty", exp_q.size(), 0);
        check_eq("total_handshakes", hs_cnt, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
